// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (main + skid) with flush and stall count.
// In_Ready is registered, so no combinational path runs from Out_Ready.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W      = 32,
  parameter bit                FLUSH_MODE  = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(32'h0000_0013),
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Flush,
  input  logic              In_Valid,
  input  logic [DATA_W-1:0] In_Data,
  output logic              In_Ready,
  output logic              Out_Valid,
  output logic [DATA_W-1:0] Out_Data,
  input  logic              Out_Ready,
  output logic [1:0]        Occupancy,
  output logic [CNT_W-1:0]  Stall_Count
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic accept;
  logic emit;

  assign accept = In_Valid & in_ready_q;
  assign emit   = m_valid_q & Out_Ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    if (Flush) begin
      s_valid_d = 1'b0;
      if (FLUSH_MODE) begin
        m_valid_d = 1'b1;
        m_data_d  = BUBBLE_DATA;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (s_valid_q) begin
      if (emit) begin
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!m_valid_q || emit) begin
        m_valid_d = 1'b1;
        m_data_d  = In_Data;
      end else begin
        s_valid_d = 1'b1;
        s_data_d  = In_Data;
      end
    end else if (emit) begin
      // Payload is left in place so Out_Data keeps its last value.
      m_valid_d = 1'b0;
    end
    in_ready_d = ~s_valid_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (m_valid_q && !Out_Ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      s_valid_q  <= 1'b0;
      s_data_q   <= '0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      s_valid_q  <= s_valid_d;
      s_data_q   <= s_data_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign In_Ready    = in_ready_q;
  assign Out_Valid   = m_valid_q;
  assign Out_Data    = m_data_q;
  assign Occupancy   = {1'b0, m_valid_q} + {1'b0, s_valid_q};
  assign Stall_Count = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: scoreboard on the default instance,
// directed checks on a FLUSH_MODE=0 / CNT_W=4 instance.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occ;
  logic [15:0] stall_cnt;

  logic        b_rst, b_flush, b_in_valid, b_out_ready;
  logic [31:0] b_in_data;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [1:0]  b_occ;
  logic [3:0]  b_stall_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .CLK(clk), .RST(rst), .Flush(flush),
    .In_Valid(in_valid), .In_Data(in_data), .In_Ready(in_ready),
    .Out_Valid(out_valid), .Out_Data(out_data), .Out_Ready(out_ready),
    .Occupancy(occ), .Stall_Count(stall_cnt)
  );

  pipe_stage_reg #(.FLUSH_MODE(1'b0), .CNT_W(4)) dut_b (
    .CLK(clk), .RST(b_rst), .Flush(b_flush),
    .In_Valid(b_in_valid), .In_Data(b_in_data), .In_Ready(b_in_ready),
    .Out_Valid(b_out_valid), .Out_Data(b_out_data), .Out_Ready(b_out_ready),
    .Occupancy(b_occ), .Stall_Count(b_stall_cnt)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a beat leaves on the coming edge when valid and ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got %h want none", out_data);
      end else begin
        check("beat", out_data, sb.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] stream[3];
    stream[0] = 32'h11;
    stream[1] = 32'h22;
    stream[2] = 32'h33;
    rst = 1; flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
    b_rst = 1; b_flush = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    step();
    step();
    rst = 0;
    b_rst = 0;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", out_data, 0);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_occ", 32'(occ), 0);
    check("rst_cnt", 32'(stall_cnt), 0);

    // Streaming
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      in_data  = stream[i];
      sb.push_back(stream[i]);
      step();
      check("stream_data", out_data, stream[i]);
      check("stream_valid", 32'(out_valid), 1);
      check("stream_ready", 32'(in_ready), 1);
    end
    in_valid = 0;
    step();
    check("stream_drain", 32'(out_valid), 0);
    check("stream_retain", out_data, 32'h33);

    // Skid
    out_ready = 0;
    in_valid = 1; in_data = 32'hA1; sb.push_back(32'hA1);
    step();
    check("skid_occ1", 32'(occ), 1);
    in_data = 32'hB2; sb.push_back(32'hB2);
    step();
    in_valid = 0;
    check("skid_occ2", 32'(occ), 2);
    check("skid_ready0", 32'(in_ready), 0);
    step();
    check("skid_hold", out_data, 32'hA1);
    check("skid_hold_occ", 32'(occ), 2);
    out_ready = 1;
    step();
    check("skid_ready1", 32'(in_ready), 1);
    check("skid_next", out_data, 32'hB2);
    step();
    check("skid_empty", 32'(occ), 0);
    out_ready = 0;

    // Flush with two held beats, offered beat discarded
    in_valid = 1; in_data = 32'hC3; sb.push_back(32'hC3);
    step();
    in_data = 32'hD4; sb.push_back(32'hD4);
    step();
    check("fl_occ2", 32'(occ), 2);
    flush = 1; in_data = 32'hE5;
    sb.delete();
    sb.push_back(32'h13);
    step();
    flush = 0; in_valid = 0;
    check("fl_valid", 32'(out_valid), 1);
    check("fl_data", out_data, 32'h13);
    check("fl_occ", 32'(occ), 1);
    check("fl_ready", 32'(in_ready), 1);
    out_ready = 1;
    step();
    check("fl_drained", 32'(out_valid), 0);

    // Accept during flush is discarded
    flush = 1; in_valid = 1; in_data = 32'hF6;
    sb.push_back(32'h13);
    step();
    flush = 0; in_valid = 0;
    check("fl_acc_data", out_data, 32'h13);
    step();
    check("fl_acc_occ", 32'(occ), 0);

    // Flush held three cycles: one bubble per cycle
    flush = 1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(32'h13);
      step();
      check("fl_hold_occ", 32'(occ <= 2'd1), 1);
      check("fl_hold_data", out_data, 32'h13);
    end
    flush = 0;
    step();
    check("fl_hold_end", 32'(out_valid), 0);

    // Reset with flush during a full stall
    out_ready = 0;
    in_valid = 1; in_data = 32'h77; sb.push_back(32'h77);
    step();
    in_data = 32'h88; sb.push_back(32'h88);
    step();
    check("rf_occ2", 32'(occ), 2);
    rst = 1; flush = 1; in_data = 32'h99;
    sb.delete();
    step();
    rst = 0; flush = 0; in_valid = 0;
    check("rf_valid", 32'(out_valid), 0);
    check("rf_data", out_data, 0);
    check("rf_ready", 32'(in_ready), 1);
    check("rf_occ", 32'(occ), 0);
    check("rf_cnt", 32'(stall_cnt), 0);
    step();
    check("rf_nobubble", 32'(out_valid), 0);

    // Post-reset beat
    out_ready = 1;
    in_valid = 1; in_data = 32'h5A; sb.push_back(32'h5A);
    step();
    in_valid = 0;
    step();
    step();
    check("sb_empty", 32'(sb.size()), 0);

    // Second instance: saturating counter and empty-mode flush
    b_in_valid = 1; b_in_data = 32'h42;
    step();
    b_in_valid = 0;
    for (int i = 0; i < 10; i++) step();
    check("cnt_10", 32'(b_stall_cnt), 10);
    for (int i = 0; i < 10; i++) step();
    check("cnt_sat", 32'(b_stall_cnt), 15);
    check("cnt_hold_data", b_out_data, 32'h42);
    step();
    check("cnt_sat2", 32'(b_stall_cnt), 15);
    b_in_valid = 1; b_in_data = 32'h43;
    step();
    b_in_valid = 0;
    check("b_occ2", 32'(b_occ), 2);
    b_flush = 1;
    step();
    b_flush = 0;
    check("b_fl_valid", 32'(b_out_valid), 0);
    check("b_fl_occ", 32'(b_occ), 0);
    check("b_fl_ready", 32'(b_in_ready), 1);
    check("b_fl_cnt", 32'(b_stall_cnt), 15);
    b_rst = 1;
    step();
    b_rst = 0;
    check("b_rst_cnt", 32'(b_stall_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: payload width in bits.
REQ-002 Parameter FLUSH_MODE, default 1: 1 = flush inserts a valid bubble; 0 = flush empties the stage.
REQ-003 Parameter BUBBLE_DATA, default 32'h0000_0013 (ADDI x0,x0,0): payload driven for an inserted bubble.
REQ-004 Parameter CNT_W, default 16: width of the stall counter.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 CLK  in  1  rising-edge clock.
REQ-007 RST  in  1  synchronous, active-high reset.
REQ-008 Flush  in  1  synchronous flush; discards the stage contents.
REQ-009 In_Valid  in  1  upstream beat present.
REQ-010 In_Data  in  DATA_W  upstream payload.
REQ-011 In_Ready  out  1  stage can accept a beat.
REQ-012 Out_Valid  out  1  downstream beat present.
REQ-013 Out_Data  out  DATA_W  downstream payload.
REQ-014 Out_Ready  in  1  downstream accepts (the inverse of a stall).
REQ-015 Occupancy  out  2  number of held beats, 0..2.
REQ-016 Stall_Count  out  CNT_W  saturating count of back-pressured cycles.

Function
REQ-017 The stage SHALL hold two entries: main (M, drives Out_Data/Out_Valid) and skid (S).
REQ-018 In_Ready SHALL equal NOT S.valid, driven from a register with no combinational path from Out_Ready.
REQ-019 Accept SHALL mean In_Valid AND In_Ready; Emit SHALL mean Out_Valid AND Out_Ready; both are evaluated on the same edge.
REQ-020 With S empty, Accept and (M empty or Emit): M <= In_Data, M.valid <= 1.
REQ-021 With S empty, Accept and M full and no Emit: S <= In_Data, S.valid <= 1, and M SHALL hold.
REQ-022 With S empty, Emit and no Accept: M.valid <= 0, and Out_Data SHALL retain its last value.
REQ-023 With S full and Emit: M <= S, S.valid <= 0; no Accept is possible in this cycle.
REQ-024 With S full and no Emit: M and S SHALL both hold.
REQ-025 Beat order SHALL be preserved, with no loss or duplication outside flush; latency is 1 cycle from Accept to Out_Valid when M is empty or emitting.
REQ-026 Out_Data and Out_Valid SHALL hold stable while Out_Valid=1 and Out_Ready=0.
REQ-027 Flush=1 SHALL, on the next edge, clear S.valid and:
- when FLUSH_MODE=1, load M with BUBBLE_DATA and set M.valid=1;
- when FLUSH_MODE=0, set M.valid=0.
REQ-028 A beat accepted in a Flush cycle SHALL be discarded; an Emit in a Flush cycle completes normally downstream.
REQ-029 Flush held for N cycles SHALL yield a single bubble per cycle and never more than one held entry (Occupancy <= 1).
REQ-030 Occupancy SHALL equal M.valid + S.valid.
REQ-031 Stall_Count SHALL increment on each edge where Out_Valid=1 and Out_Ready=0.
REQ-032 Stall_Count SHALL saturate at 2^CNT_W-1 and is cleared only by RST.

Reset
REQ-033 RST=1 SHALL, on the next edge, set M.valid=0, S.valid=0, Out_Data=0, Stall_Count=0, Occupancy=0 and In_Ready=1.
REQ-034 RST SHALL take priority over Flush and over any handshake, and a beat offered during RST is dropped.
REQ-035 Reset asserted mid-stall with Occupancy=2 SHALL empty both entries in one cycle.

Verification
REQ-036 Streaming: Out_Ready=1, beats 0x11,0x22,0x33 on consecutive cycles -> Out_Data 0x11,0x22,0x33 one cycle later, and In_Ready stays 1.
REQ-037 Skid: M=0xA1 held, Out_Ready=0, offer 0xB2 -> Occupancy=2 and In_Ready=0; then Out_Ready=1 -> 0xA1 then 0xB2, and In_Ready returns to 1 after 0xA1 emits.
REQ-038 Flush, FLUSH_MODE=1, Occupancy=2 -> next cycle Out_Valid=1, Out_Data=0x0000_0013, Occupancy=1, and a beat offered in the flush cycle never appears.
REQ-039 Flush, FLUSH_MODE=0 -> next cycle Out_Valid=0, Occupancy=0.
REQ-040 Counter: CNT_W=4, Out_Valid=1, Out_Ready=0 for 20 cycles -> Stall_Count=15 and holds; RST -> 0.
REQ-041 RST and Flush asserted together with Occupancy=2 -> Out_Valid=0, Out_Data=0, In_Ready=1, and no bubble appears.
